// File: rtl/dma_priority_resolver.sv
// DMA channel arbiter: qualifies DREQ, picks a winner under fixed or
// rotating priority, and runs the HRQ/HLDA/DACK handshake per transfer.
module dma_priority_resolver (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic [3:0] softwareReq,
  input  logic       priorityType,
  input  logic       controllerDisable,
  input  logic       HLDA,
  input  logic       cycleDone,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       assertDACK,
  output logic [1:0] activeChannel,
  output logic [7:0] priorityOrder
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    REQ   = 3'b010,
    GRANT = 3'b100
  } state_t;

  localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

  state_t     state_q, state_n;
  logic       hrq_q, hrq_n;
  logic [3:0] dack_q, dack_n;
  logic [1:0] ach_q, ach_n;
  logic [7:0] po_q, po_n;
  logic [3:0] eff_req;
  logic [1:0] winner;

  assign eff_req = controllerDisable ? 4'b0000
                 : (DREQ | softwareReq) & ~maskReg;

  // Scan lowest-priority field first so the highest match overwrites.
  always_comb begin
    winner = po_q[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (eff_req[po_q[2*i +: 2]]) winner = po_q[2*i +: 2];
    end
  end

  always_comb begin
    state_n = state_q;
    hrq_n   = hrq_q;
    dack_n  = dack_q;
    ach_n   = ach_q;
    po_n    = po_q;
    unique case (1'b1)
      state_q[0]: begin
        if (!priorityType) po_n = FIXED_ORDER;
        if (eff_req != 4'b0000) begin
          state_n = REQ;
          hrq_n   = 1'b1;
        end
      end
      state_q[1]: begin
        if (eff_req == 4'b0000) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
        end else if (HLDA) begin
          state_n = GRANT;
          ach_n   = winner;
          dack_n  = 4'b0001 << winner;
        end
      end
      state_q[2]: begin
        if (cycleDone) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
          dack_n  = 4'b0000;
          if (priorityType)
            po_n = {ach_q, ach_q + 2'd3,
                    ach_q + 2'd2, ach_q + 2'd1};
        end else if (!HLDA) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
          dack_n  = 4'b0000;
        end
      end
      default: begin
        state_n = IDLE;
        hrq_n   = 1'b0;
        dack_n  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= 4'b0000;
      ach_q   <= 2'b00;
      po_q    <= FIXED_ORDER;
    end else begin
      state_q <= state_n;
      hrq_q   <= hrq_n;
      dack_q  <= dack_n;
      ach_q   <= ach_n;
      po_q    <= po_n;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign assertDACK    = |dack_q;
  assign activeChannel = ach_q;
  assign priorityOrder = po_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver with
// hand-computed expectations checked by immediate assertions.
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic [3:0] softwareReq;
  logic       priorityType;
  logic       controllerDisable;
  logic       HLDA;
  logic       cycleDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       assertDACK;
  logic [1:0] activeChannel;
  logic [7:0] priorityOrder;

  int errors = 0;
  int checks = 0;

  dma_priority_resolver dut (
    .CLK(CLK),
    .RESET(RESET),
    .DREQ(DREQ),
    .maskReg(maskReg),
    .softwareReq(softwareReq),
    .priorityType(priorityType),
    .controllerDisable(controllerDisable),
    .HLDA(HLDA),
    .cycleDone(cycleDone),
    .HRQ(HRQ),
    .DACK(DACK),
    .assertDACK(assertDACK),
    .activeChannel(activeChannel),
    .priorityOrder(priorityOrder)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From IDLE with a request present and HLDA high: HRQ, then DACK,
  // then release via cycleDone.
  task automatic grant(input string tag,
                       input logic [3:0] exp_dack,
                       input logic [7:0] exp_po);
    tick();
    chk({tag, "_hrq"}, {7'd0, HRQ}, 8'd1);
    tick();
    chk({tag, "_dack"}, {4'd0, DACK}, {4'd0, exp_dack});
    chk({tag, "_adack"}, {7'd0, assertDACK}, 8'd1);
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0;
    chk({tag, "_rel"}, {3'd0, HRQ, DACK}, 8'd0);
    chk({tag, "_po"}, priorityOrder, exp_po);
  endtask

  initial begin
    RESET = 1'b1;
    DREQ = 4'b0000;
    maskReg = 4'b0000;
    softwareReq = 4'b0000;
    priorityType = 1'b0;
    controllerDisable = 1'b0;
    HLDA = 1'b0;
    cycleDone = 1'b0;
    #3;
    chk("rst_hrq", {7'd0, HRQ}, 8'd0);
    chk("rst_dack", {4'd0, DACK}, 8'd0);
    chk("rst_adack", {7'd0, assertDACK}, 8'd0);
    chk("rst_ach", {6'd0, activeChannel}, 8'd0);
    chk("rst_po", priorityOrder, 8'hE4);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Fixed priority
    HLDA = 1'b1;
    DREQ = 4'b0011;
    grant("fix0", 4'b0001, 8'hE4);
    DREQ = 4'b1110;
    grant("fix1", 4'b0010, 8'hE4);
    chk("fix1_ach_hold", {6'd0, activeChannel}, 8'd1);
    DREQ = 4'b1111;
    grant("fix2", 4'b0001, 8'hE4);

    // Rotating priority, all requests held
    priorityType = 1'b1;
    grant("rot0", 4'b0001, 8'h39);
    grant("rot1", 4'b0010, 8'h4E);
    grant("rot2", 4'b0100, 8'h93);
    grant("rot3", 4'b1000, 8'hE4);
    grant("rot4", 4'b0001, 8'h39);

    // Masking and software request
    DREQ = 4'b0000;
    priorityType = 1'b0;
    tick();
    chk("fix_reload", priorityOrder, 8'hE4);
    maskReg = 4'b0001;
    DREQ = 4'b0011;
    grant("mask", 4'b0010, 8'hE4);
    maskReg = 4'b0000;
    DREQ = 4'b0000;
    softwareReq = 4'b1000;
    grant("swreq", 4'b1000, 8'hE4);
    softwareReq = 4'b0000;
    controllerDisable = 1'b1;
    DREQ = 4'b1111;
    tick();
    chk("dis_hrq0", {7'd0, HRQ}, 8'd0);
    tick();
    chk("dis_hrq1", {7'd0, HRQ}, 8'd0);
    controllerDisable = 1'b0;
    DREQ = 4'b0000;
    tick();

    // Request withdrawn before HLDA
    HLDA = 1'b0;
    DREQ = 4'b0001;
    tick();
    chk("wd_hrq", {7'd0, HRQ}, 8'd1);
    DREQ = 4'b0000;
    tick();
    chk("wd_drop", {3'd0, HRQ, DACK}, 8'd0);
    HLDA = 1'b1;
    tick();
    chk("wd_idle", {3'd0, HRQ, DACK}, 8'd0);

    // HLDA dropped in GRANT: no rotation
    priorityType = 1'b1;
    DREQ = 4'b0100;
    tick();
    chk("hl_hrq", {7'd0, HRQ}, 8'd1);
    tick();
    chk("hl_dack", {4'd0, DACK}, 8'h04);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    tick();
    chk("hl_rel", {3'd0, HRQ, DACK}, 8'd0);
    chk("hl_po", priorityOrder, 8'hE4);

    // cycleDone with HLDA low together: rotation applies
    HLDA = 1'b1;
    DREQ = 4'b0010;
    tick();
    tick();
    chk("cd_dack", {4'd0, DACK}, 8'h02);
    DREQ = 4'b0000;
    cycleDone = 1'b1;
    HLDA = 1'b0;
    tick();
    cycleDone = 1'b0;
    chk("cd_rel", {3'd0, HRQ, DACK}, 8'd0);
    chk("cd_po", priorityOrder, 8'h4E);

    // Asynchronous reset during GRANT
    priorityType = 1'b0;
    HLDA = 1'b1;
    DREQ = 4'b0100;
    tick();
    tick();
    tick();
    chk("ar_dack", {4'd0, DACK}, 8'h04);
    chk("ar_ach", {6'd0, activeChannel}, 8'd2);
    #2 RESET = 1'b1;
    #1;
    chk("ar_clr", {3'd0, HRQ, DACK}, 8'd0);
    chk("ar_ach0", {6'd0, activeChannel}, 8'd0);
    #1 RESET = 1'b0;
    tick();
    chk("ar_hrq", {7'd0, HRQ}, 8'd1);
    tick();
    chk("ar_regrant", {4'd0, DACK}, 8'h04);
    DREQ = 4'b0000;
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0;
    chk("ar_rel", {3'd0, HRQ, DACK}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
